// File: rtl/vga_timing_gen_param_if.sv
// vga_timing_gen_param_if: pixel-request and video-output bundle of the timing generator
interface vga_timing_gen_param_if #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 12
);
  logic               timing_en;
  logic [3*PIX_W-1:0] pix_rgb;
  logic               pix_req;
  logic [CNT_W-1:0]   req_x;
  logic [CNT_W-1:0]   req_y;
  logic               frame_start;
  logic               running;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_de;
  logic [3*PIX_W-1:0] vga_rgb;
  modport master (
    input  timing_en, pix_rgb,
    output pix_req, req_x, req_y, frame_start, running, vga_hs, vga_vs, vga_de, vga_rgb
  );
  modport slave (
    output timing_en, pix_rgb,
    input  pix_req, req_x, req_y, frame_start, running, vga_hs, vga_vs, vga_de, vga_rgb
  );
endinterface

// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param: parametrised video timing generator with look-ahead pixel requests
module vga_timing_gen_param #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int PIX_W    = 8,
  parameter int REQ_LEAD = 2,
  parameter int CNT_W    = 12
) (
  input logic                    pix_clk,
  input logic                    reset_n,
  vga_timing_gen_param_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_OFF = ~VS_ON;

  if (REQ_LEAD < 1 || REQ_LEAD > 8) begin : g_lead_chk
    $error("REQ_LEAD must be within 1..8");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_chk
    $error("CNT_W too narrow for the frame totals");
  end

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  typedef struct packed {
    logic run;
    logic hs;
    logic vs;
    logic de;
  } tap_t;
  localparam tap_t TAP_OFF = '{run: 1'b0, hs: HS_OFF, vs: VS_OFF, de: 1'b0};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0]   req_x_q, req_y_q;
  logic               fs_q;
  logic [3*PIX_W-1:0] rgb_q;
  tap_t               tap_d;
  tap_t               dly_q [REQ_LEAD+1];
  logic               h_end, v_end, go, h_act, v_act, h_syn, v_syn;

  assign h_end = h_q == CNT_W'(H_TOTAL - 1);
  assign v_end = v_q == CNT_W'(V_TOTAL - 1);

  // state register, reset straight to IDLE so a reset aborts any frame in flight
  always_ff @(posedge pix_clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;

  // start is taken at once from IDLE; a stop request only lands at the last pixel of a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.timing_en ? RUN : IDLE;
      RUN:     state_d = bus.timing_en ? RUN : STOP;
      default: state_d = (h_end && v_end) ? (bus.timing_en ? RUN : IDLE) : STOP;
    endcase
  end

  // raster counters: parked at the origin in IDLE, otherwise step and wrap
  always_comb begin
    h_d = (state_q == IDLE || h_end) ? '0 : h_q + CNT_W'(1);
    v_d = (state_q == IDLE || (h_end && v_end)) ? '0 : (h_end ? v_q + CNT_W'(1) : v_q);
  end

  // early timing is derived from the next counter values so it registers alongside them
  always_comb begin
    go    = state_d != IDLE;
    h_act = h_d < CNT_W'(H_ACTIVE);
    v_act = v_d < CNT_W'(V_ACTIVE);
    h_syn = h_d >= CNT_W'(H_ACTIVE + H_FP) && h_d < CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    v_syn = v_d >= CNT_W'(V_ACTIVE + V_FP) && v_d < CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    tap_d = '{run: go,
              hs:  (go && h_syn) ? HS_ON : HS_OFF,
              vs:  (go && v_syn) ? VS_ON : VS_OFF,
              de:  go && h_act && v_act};
  end

  // counter registers
  always_ff @(posedge pix_clk or negedge reset_n)
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end

  // request coordinates and frame marker, zeroed outside the active area
  always_ff @(posedge pix_clk or negedge reset_n)
    if (!reset_n) begin
      req_x_q <= '0;
      req_y_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      req_x_q <= tap_d.de ? h_d : '0;
      req_y_q <= tap_d.de ? v_d : '0;
      fs_q    <= go && h_d == '0 && v_d == '0;
    end

  // stage 0 is the early timing; stage REQ_LEAD drives the pins, and it keeps flushing in IDLE
  always_ff @(posedge pix_clk or negedge reset_n)
    if (!reset_n) for (int k = 0; k <= REQ_LEAD; k++) dly_q[k] <= TAP_OFF;
    else begin
      dly_q[0] <= tap_d;
      for (int k = 1; k <= REQ_LEAD; k++) dly_q[k] <= dly_q[k-1];
    end

  // upstream pixel is captured on the edge that moves its DE onto the pins
  always_ff @(posedge pix_clk or negedge reset_n)
    if (!reset_n) rgb_q <= '0;
    else rgb_q <= dly_q[REQ_LEAD-1].de ? bus.pix_rgb : '0;

  assign bus.pix_req     = dly_q[0].de;
  assign bus.req_x       = req_x_q;
  assign bus.req_y       = req_y_q;
  assign bus.frame_start = fs_q;
  assign bus.running     = dly_q[REQ_LEAD].run;
  assign bus.vga_hs      = dly_q[REQ_LEAD].hs;
  assign bus.vga_vs      = dly_q[REQ_LEAD].vs;
  assign bus.vga_de      = dly_q[REQ_LEAD].de;
  assign bus.vga_rgb     = rgb_q;
endmodule

// File: tb/tb_vga_timing_gen_param.sv
// tb_vga_timing_gen_param: randomized run/stop stimulus checked against a frame-position model
module tb_vga_timing_gen_param;
  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int L = 2, PW = 8, CW = 12;
  localparam bit HP = 1'b0, VP = 1'b1;

  logic pix_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 pix_clk = ~pix_clk;

  vga_timing_gen_param_if #(.PIX_W(PW), .CNT_W(CW)) bus ();

  vga_timing_gen_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(int'(HP)), .VS_POL(int'(VP)), .PIX_W(PW), .REQ_LEAD(L), .CNT_W(CW)
  ) dut (
    .pix_clk(pix_clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int errors = 0, checks = 0, cyc = 0;
  int last_fs = -1, de_frame = 0, fs_cnt = 0, hs_low = 0, vs_high = 0;
  bit chk_period = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] pat(input int x, input int y);
    return {8'(y), 8'(x), 8'(x ^ y ^ 165)};
  endfunction

  task automatic step();
    @(negedge pix_clk);
    #2;
  endtask

  task automatic wait_req(input int x, input int y);
    int n = 0;
    while (!(bus.pix_req && bus.req_x == CW'(x) && bus.req_y == CW'(y)) && n < 4 * FT) begin
      step();
      n++;
    end
    if (n >= 4 * FT) begin
      checks++;
      errors++;
      $display("FAIL wait_req(%0d,%0d): not seen within %0d cycles", x, y, 4 * FT);
    end
  endtask

  // model: a frame is either off, running, or finishing; position p counts pixels in the frame
  bit m_run = 1'b0, m_stop = 1'b0;
  int m_p = 0;
  bit hr [L+1];
  int hp [L+1];
  bit rv [L];
  logic [CW-1:0] rx [L], ry [L];

  initial begin
    int x, y, ox, oy;
    bit act, ode;
    for (int k = 0; k <= L; k++) begin hr[k] = 1'b0; hp[k] = 0; end
    for (int k = 0; k < L; k++) begin rv[k] = 1'b0; rx[k] = '0; ry[k] = '0; end
    bus.pix_rgb = '0;
    forever begin
      @(negedge pix_clk);
      cyc++;
      if (!reset_n) begin
        m_run = 1'b0; m_stop = 1'b0; m_p = 0;
        for (int k = 0; k <= L; k++) begin hr[k] = 1'b0; hp[k] = 0; end
      end else begin
        if (!m_run) begin
          if (bus.timing_en) begin m_run = 1'b1; m_stop = 1'b0; m_p = 0; end
        end else begin
          if (m_stop && m_p == FT - 1) begin
            if (bus.timing_en) m_stop = 1'b0;
            else m_run = 1'b0;
          end else if (!m_stop && !bus.timing_en) m_stop = 1'b1;
          m_p = (m_p + 1) % FT;
        end
        for (int k = L; k > 0; k--) begin hr[k] = hr[k-1]; hp[k] = hp[k-1]; end
        hr[0] = m_run;
        hp[0] = m_p;
      end
      x = m_p % HT; y = m_p / HT;
      act = m_run && x < HA && y < VA;
      chk("pix_req", bus.pix_req, act);
      chk("req_x", bus.req_x, act ? x : 0);
      chk("req_y", bus.req_y, act ? y : 0);
      chk("frame_start", bus.frame_start, m_run && m_p == 0);
      ox = hp[L] % HT; oy = hp[L] / HT;
      ode = hr[L] && ox < HA && oy < VA;
      chk("vga_de", bus.vga_de, ode);
      chk("vga_hs", bus.vga_hs, (hr[L] && ox >= HA + HFP && ox < HA + HFP + HSW) ? HP : !HP);
      chk("vga_vs", bus.vga_vs, (hr[L] && oy >= VA + VFP && oy < VA + VFP + VSW) ? VP : !VP);
      chk("vga_rgb", bus.vga_rgb, ode ? pat(ox, oy) : 24'h0);
      chk("running", bus.running, hr[L]);
      if (bus.vga_de) de_frame++;
      if (bus.frame_start) begin
        fs_cnt++;
        if (chk_period && last_fs >= 0) begin
          chk("fs_period", cyc - last_fs, 128);
          chk("de_per_frame", de_frame, 32);
        end
        last_fs = cyc;
        de_frame = 0;
      end
      if (!chk_period || !reset_n) last_fs = -1;
      if (!reset_n) begin hs_low = 0; vs_high = 0; end
      else begin
        if (bus.vga_hs == 1'b0) hs_low++;
        else begin if (hs_low > 0) chk("hsync_width", hs_low, 3); hs_low = 0; end
        if (bus.vga_vs == 1'b1) vs_high++;
        else begin if (vs_high > 0) chk("vsync_width", vs_high, 32); vs_high = 0; end
      end
      for (int k = L - 1; k > 0; k--) begin rv[k] = rv[k-1]; rx[k] = rx[k-1]; ry[k] = ry[k-1]; end
      rv[0] = reset_n && bus.pix_req; rx[0] = bus.req_x; ry[0] = bus.req_y;
      bus.pix_rgb = rv[L-1] ? pat(int'(rx[L-1]), int'(ry[L-1])) : 24'($urandom);
    end
  end

  initial begin
    int n, fs0;
    bus.timing_en = 1'b0;
    reset_n = 1'b0;
    repeat (5) step();
    reset_n = 1'b1;
    repeat (200) step();
    chk("idle_hs", bus.vga_hs, 1'b1);
    chk("idle_vs", bus.vga_vs, 1'b0);
    chk("idle_req", bus.pix_req, 1'b0);
    chk_period = 1'b1;
    bus.timing_en = 1'b1;
    step();
    chk("first_req", {bus.pix_req, bus.req_x, bus.req_y}, {1'b1, 12'd0, 12'd0});
    repeat (3 * FT) step();
    wait_req(5, 2);
    chk_period = 1'b0;
    bus.timing_en = 1'b0;
    fs0 = fs_cnt;
    n = 0;
    while (bus.running && n < 2 * FT) begin step(); n++; end
    chk("stop_bounded", n < 2 * FT, 1'b1);
    chk("stop_de_count", de_frame, 32);
    repeat (100) step();
    chk("no_fs_after_stop", fs_cnt, fs0);
    bus.timing_en = 1'b1;
    chk_period = 1'b1;
    wait_req(2, 1);
    bus.timing_en = 1'b0;
    step();
    bus.timing_en = 1'b1;
    repeat (3 * FT) step();
    chk_period = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) bus.timing_en = ~bus.timing_en;
      step();
    end
    bus.timing_en = 1'b1;
    wait_req(3, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst", {bus.pix_req, bus.req_x, bus.req_y, bus.frame_start, bus.running,
                      bus.vga_de, bus.vga_hs, bus.vga_vs, bus.vga_rgb},
        {1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0});
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("req_after_rst", {bus.pix_req, bus.req_x, bus.req_y}, {1'b1, 12'd0, 12'd0});
    repeat (FT + 10) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
